// File: rtl/div5_recombine_serial_pkg.sv
// Shared constants and types for the digit-serial 5*q + r recombiner.
// Optional feature macro: DIV5_RECOMBINE_REM_CHECK_EN (remainder range flag).
package div5_pkg;

   localparam int W       = 64;
   localparam int DIGIT_W = 3;
   localparam int NDIG    = (W + DIGIT_W - 1) / DIGIT_W;
   localparam int ACC_W   = DIGIT_W * NDIG;
   localparam int DIVISOR = 5;
   localparam int REM_W   = 3;
   localparam int CARRY_W = 3;
   localparam int CNT_W   = 5;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div5_recombine_serial_mul_digit.sv
// One radix-8 step of 5*q + carry: six inputs, six outputs, a single LUT6 level.
// Carry stays within 0..5 because 5*7 + 7 = 42 < 48.
module div5_mul_digit
   import div5_pkg::*;
(
   input  logic [DIGIT_W-1:0] d,
   input  logic [CARRY_W-1:0] c_in,
   output logic [DIGIT_W-1:0] digit,
   output logic [CARRY_W-1:0] c_out
);

   logic [5:0] sum;

   // Multiply the digit by the divisor and add the incoming carry, then split the sum.
   always_comb begin
      sum   = 6'({3'b000, d} * 6'(DIVISOR)) + {3'b000, c_in};
      digit = sum[DIGIT_W-1:0];
      c_out = sum[5:DIGIT_W];
   end

endmodule

// File: rtl/div5_recombine_serial.sv
// Digit-serial recombiner: x = 5*q + r, LSB first, one 3-bit digit per cycle.
// Optional feature macro: DIV5_RECOMBINE_REM_CHECK_EN flags in_r >= 5 alongside the result.
module div5_recombine_serial
   import div5_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_q,
   input  logic [REM_W-1:0]   in_r,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       out_x,
   output logic               out_ovf,
   output logic               out_rem_err
);

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     cnt;
   logic [ACC_W-1:0]     q_sr;
   logic [ACC_W-1:0]     acc;
   logic [ACC_W-1:0]     acc_next;
   logic [CARRY_W-1:0]   carry;
   logic [DIGIT_W-1:0]   step_digit;
   logic [CARRY_W-1:0]   step_carry;
   logic                 last_digit;

   div5_mul_digit u_mul_digit (
      .d     (q_sr[DIGIT_W-1:0]),
      .c_in  (carry),
      .digit (step_digit),
      .c_out (step_carry)
   );

   assign acc_next   = {step_digit, acc[ACC_W-1:DIGIT_W]};
   assign last_digit = (cnt == CNT_LAST);

   // State register; reset aborts any operation in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode: accept only when idle, present only when done.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_digit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Serial datapath: the remainder seeds the carry, digits shift into acc from the top.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         q_sr    <= '0;
         acc     <= '0;
         carry   <= '0;
         out_x   <= '0;
         out_ovf <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  q_sr  <= {{(ACC_W - W){1'b0}}, in_q};
                  carry <= in_r;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               q_sr  <= q_sr >> DIGIT_W;
               acc   <= acc_next;
               carry <= step_carry;
               cnt   <= cnt + CNT_W'(1);
               if (last_digit) begin
                  out_x   <= acc_next[W-1:0];
                  out_ovf <= (|acc_next[ACC_W-1:W]) | (step_carry != '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef DIV5_RECOMBINE_REM_CHECK_EN
   logic rem_err;

   // Flag an out-of-range remainder at accept; it then travels with the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_err <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         rem_err <= (in_r >= REM_W'(DIVISOR));
      end
   end

   assign out_rem_err = rem_err;
`else
   assign out_rem_err = 1'b0;
`endif

endmodule
